// File: rtl/vga_sync_receiver.sv
// Sink-side VGA sync receiver: recovers pixel position and data-enable from active-low
// hsync/vsync, checks line/frame lengths against nominal timing and reports lock/error.
module vga_sync_receiver #(
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_TOTAL    = 525,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hsync,
    input  logic       i_vsync,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_de,
    output logic       o_h_locked,
    output logic       o_v_locked,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic       o_h_err,
    output logic       o_v_err
);

    localparam logic [9:0] LP_CNT_MAX = 10'd1023;
    localparam logic [9:0] LP_CNT_PRE = 10'd1022;
    localparam logic [9:0] LP_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] LP_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] LP_H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] LP_H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] LP_V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] LP_V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [2:0] LP_LOCK    = 3'(LOCK_COUNT);

    logic       r_hs_d;
    logic       r_vs_d;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_v_pend;
    logic       r_h_seen;
    logic       r_v_seen;
    logic [2:0] r_h_lock_cnt;
    logic [2:0] r_v_lock_cnt;
    logic       r_line_start;
    logic       r_frame_start;
    logic       r_h_err;
    logic       r_v_err;

    logic       w_h_fe;
    logic       w_v_fe;
    logic       w_h_good;
    logic       w_h_bad;
    logic       w_h_tmo;
    logic       w_h_lose;
    logic       w_v_load;
    logic       w_v_good;
    logic       w_v_bad;
    logic [9:0] w_h_cnt_d;
    logic [9:0] w_v_cnt_d;
    logic       w_v_pend_d;
    logic       w_h_seen_d;
    logic       w_v_seen_d;
    logic [2:0] w_h_lock_cnt_d;
    logic [2:0] w_v_lock_cnt_d;
    logic       w_h_act;
    logic       w_v_act;

    // Event decode: edges, line/frame verdicts and the hsync timeout entry.
    always_comb begin
        w_h_fe   = r_hs_d & ~i_hsync;
        w_v_fe   = r_vs_d & ~i_vsync;
        w_h_good = w_h_fe & r_h_seen & (r_h_cnt == LP_H_LAST);
        w_h_bad  = w_h_fe & r_h_seen & (r_h_cnt != LP_H_LAST);
        w_h_tmo  = ~w_h_fe & (r_h_cnt == LP_CNT_PRE);
        w_h_lose = w_h_bad | w_h_tmo;
        w_v_load = w_h_fe & (r_v_pend | w_v_fe);
        w_v_good = w_v_load & r_v_seen & (r_v_cnt == LP_V_LAST);
        w_v_bad  = w_v_load & r_v_seen & (r_v_cnt != LP_V_LAST);
    end

    always_comb begin
        w_h_cnt_d      = r_h_cnt;
        w_v_cnt_d      = r_v_cnt;
        w_v_pend_d     = r_v_pend;
        w_h_seen_d     = r_h_seen;
        w_v_seen_d     = r_v_seen;
        w_h_lock_cnt_d = r_h_lock_cnt;
        w_v_lock_cnt_d = r_v_lock_cnt;

        if (w_h_fe) begin
            w_h_cnt_d = '0;
        end else if (r_h_cnt != LP_CNT_MAX) begin
            w_h_cnt_d = r_h_cnt + 10'd1;
        end

        if (w_h_tmo) begin
            w_h_seen_d = 1'b0;
        end else if (w_h_fe) begin
            w_h_seen_d = 1'b1;
        end

        if (w_h_lose) begin
            w_h_lock_cnt_d = '0;
        end else if (w_h_good && (r_h_lock_cnt != LP_LOCK)) begin
            w_h_lock_cnt_d = r_h_lock_cnt + 3'd1;
        end

        // vsync edge is latched until the next line start so frames align to h_fe.
        if (w_v_load) begin
            w_v_cnt_d  = '0;
            w_v_pend_d = 1'b0;
            w_v_seen_d = 1'b1;
        end else begin
            if (w_h_fe && (r_v_cnt != LP_CNT_MAX)) begin
                w_v_cnt_d = r_v_cnt + 10'd1;
            end
            if (w_v_fe) begin
                w_v_pend_d = 1'b1;
            end
        end

        if (w_h_lose || w_v_bad) begin
            w_v_lock_cnt_d = '0;
        end else if (w_v_good && (r_v_lock_cnt != LP_LOCK)) begin
            w_v_lock_cnt_d = r_v_lock_cnt + 3'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hs_d        <= 1'b1;
            r_vs_d        <= 1'b1;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_v_pend      <= 1'b0;
            r_h_seen      <= 1'b0;
            r_v_seen      <= 1'b0;
            r_h_lock_cnt  <= '0;
            r_v_lock_cnt  <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
        end else begin
            r_hs_d        <= i_hsync;
            r_vs_d        <= i_vsync;
            r_h_cnt       <= w_h_cnt_d;
            r_v_cnt       <= w_v_cnt_d;
            r_v_pend      <= w_v_pend_d;
            r_h_seen      <= w_h_seen_d;
            r_v_seen      <= w_v_seen_d;
            r_h_lock_cnt  <= w_h_lock_cnt_d;
            r_v_lock_cnt  <= w_v_lock_cnt_d;
            r_line_start  <= w_h_fe;
            r_frame_start <= w_v_load;
            r_h_err       <= w_h_lose;
            r_v_err       <= w_v_bad;
        end
    end

    always_comb begin
        w_h_act       = (r_h_cnt >= LP_H_START) && (r_h_cnt <= LP_H_END);
        w_v_act       = (r_v_cnt >= LP_V_START) && (r_v_cnt <= LP_V_END);
        o_x           = w_h_act ? (r_h_cnt - LP_H_START) : '0;
        o_y           = w_v_act ? (r_v_cnt - LP_V_START) : '0;
        o_h_locked    = (r_h_lock_cnt == LP_LOCK);
        o_v_locked    = (r_v_lock_cnt == LP_LOCK);
        o_de          = w_h_act & w_v_act & o_h_locked & o_v_locked;
        o_line_start  = r_line_start;
        o_frame_start = r_frame_start;
        o_h_err       = r_h_err;
        o_v_err       = r_v_err;
    end

endmodule
